bm_dag3_sink: RTL and testbench

BM_DAG3_SINK -- requirements
Module: bm_dag3_sink

---
 rtl/bm_dag3_sink_if.sv | 30 +++
 rtl/bm_dag3_sink.sv | 135 +++++++++++++
 tb/tb_bm_dag3_sink.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/bm_dag3_sink_if.sv
// Producer/consumer bundle for bm_dag3_sink: write side (data, flag, valid), read side
// (pop request and popped entry), plus occupancy, detector and overflow status.
interface bm_dag3_sink_if #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BITS-1:0] data_in;
    logic            flag_in;
    logic            in_valid;
    logic            rd_en;
    logic [BITS:0]   rd_data;
    logic            rd_valid;
    logic            empty;
    logic            full;
    logic [CW-1:0]   count;
    logic            match;
    logic            overflow;

    modport master (
        output data_in, flag_in, in_valid, rd_en,
        input  rd_data, rd_valid, empty, full, count, match, overflow
    );

    modport slave (
        input  data_in, flag_in, in_valid, rd_en,
        output rd_data, rd_valid, empty, full, count, match, overflow
    );
endinterface

// File: rtl/bm_dag3_sink.sv
// Flag/data sink FIFO with a 1,1,0 flag-sequence detector; pops land one cycle after rd_en.
// No backpressure upstream: writes while full are dropped and latch a sticky overflow.
module bm_dag3_sink #(
    parameter int BITS  = 2,
    parameter int DEPTH = 4
) (
    input logic          clock,
    input logic          reset_n,
    bm_dag3_sink_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_S1   = 2'd1,
        ST_S11  = 2'd2
    } det_state_e;

    logic [BITS:0]   mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic [BITS:0]   rd_data_q, rd_data_d;
    logic            rd_valid_q, rd_valid_d;
    logic            overflow_q, overflow_d;
    logic            match_q, match_d;
    det_state_e      state_q, state_d;
    logic            wr_go;
    logic            rd_go;

    // Both decisions use pre-edge flags, so a full FIFO never accepts a write on a pop cycle.
    always_comb begin
        wr_go = bus.in_valid && !full_q;
        rd_go = bus.rd_en && !empty_q;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_go;
        overflow_d = overflow_q | (bus.in_valid & full_q);

        if (wr_go) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_go) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem_q[rd_ptr_q];
        end

        case ({wr_go, rd_go})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not cleared by reset; the pointers alone define what is live.
    always_ff @(posedge clock) begin
        if (reset_n && wr_go) begin
            mem_q[wr_ptr_q] <= {bus.flag_in, bus.data_in};
        end
    end

    // Detector: state register
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
        end
    end

    // Detector: next state, advancing on every in_valid regardless of FIFO acceptance
    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                ST_IDLE: state_d = bus.flag_in ? ST_S1  : ST_IDLE;
                ST_S1:   state_d = bus.flag_in ? ST_S11 : ST_IDLE;
                ST_S11:  state_d = bus.flag_in ? ST_S11 : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Detector: output
    always_comb begin
        match_d = bus.in_valid && !bus.flag_in && (state_q == ST_S11);
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.count    = count_q;
    assign bus.match    = match_q;
    assign bus.overflow = overflow_q;

    a_empty_full_excl: assert property (@(posedge clock) disable iff (!reset_n)
        !(empty_q && full_q));

endmodule

// File: tb/tb_bm_dag3_sink.sv
// Directed bench for bm_dag3_sink: queue-based reference model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_bm_dag3_sink;
    localparam int BITS  = 2;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    bm_dag3_sink_if #(.BITS(BITS), .DEPTH(DEPTH)) bus ();
    bm_dag3_sink #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordinary queue plus the last two valid flags.
    logic [BITS:0] mq[$];
    logic [BITS:0] m_rd_data  = '0;
    bit            m_rd_valid = 0;
    bit            m_match    = 0;
    bit            m_ovf      = 0;
    bit            m_live     = 0;
    bit            h1 = 0, h2 = 0;
    bit            do_rd, do_wr, was_full;

    always @(posedge clock) begin
        m_live = 1;
        if (!reset_n) begin
            mq.delete();
            m_rd_data  = '0;
            m_rd_valid = 0;
            m_match    = 0;
            m_ovf      = 0;
            h1 = 0;
            h2 = 0;
        end else begin
            was_full   = (mq.size() == DEPTH);
            do_rd      = bus.rd_en && (mq.size() != 0);
            do_wr      = bus.in_valid && !was_full;
            m_rd_valid = do_rd;
            if (do_rd) m_rd_data = mq.pop_front();
            if (do_wr) mq.push_back({bus.flag_in, bus.data_in});
            if (bus.in_valid && was_full) m_ovf = 1;
            m_match = bus.in_valid && !bus.flag_in && h1 && h2;
            if (bus.in_valid) begin
                h2 = h1;
                h1 = bus.flag_in;
            end
        end
    end

    always @(negedge clock) begin
        if (m_live) begin
            chk("rd_valid", 32'(bus.rd_valid), 32'(m_rd_valid));
            chk("rd_data",  32'(bus.rd_data),  32'(m_rd_data));
            chk("count",    32'(bus.count),    32'(mq.size()));
            chk("empty",    32'(bus.empty),    32'(mq.size() == 0));
            chk("full",     32'(bus.full),     32'(mq.size() == DEPTH));
            chk("match",    32'(bus.match),    32'(m_match));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    task automatic cyc(input logic iv, input logic [BITS-1:0] d, input logic f, input logic re);
        bus.in_valid = iv;
        bus.data_in  = d;
        bus.flag_in  = f;
        bus.rd_en    = re;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [BITS:0] ent(input int j);
        logic [31:0] v;
        v = 32'(j);
        return {v[0], v[1:0]};
    endfunction

    initial begin
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        bus.flag_in  = 1'b0;
        bus.rd_en    = 1'b0;
        cyc(1, 2'b11, 1, 1);
        cyc(1, 2'b11, 1, 1);
        reset_n = 1'b1;
        chk("rst_count", 32'(bus.count), 0);
        chk("rst_empty", 32'(bus.empty), 1);
        chk("rst_full", 32'(bus.full), 0);
        chk("rst_ovf", 32'(bus.overflow), 0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);

        // Basic ordering
        cyc(1, 2'b01, 0, 0);
        cyc(1, 2'b10, 1, 0);
        cyc(1, 2'b11, 0, 0);
        chk("fill3_count", 32'(bus.count), 3);
        cyc(0, 2'b00, 0, 1);
        chk("pop1_data", 32'(bus.rd_data), 32'(3'b001));
        chk("pop1_vld", 32'(bus.rd_valid), 1);
        cyc(0, 2'b00, 0, 1);
        chk("pop2_data", 32'(bus.rd_data), 32'(3'b110));
        chk("pop2_vld", 32'(bus.rd_valid), 1);
        cyc(0, 2'b00, 0, 1);
        chk("pop3_data", 32'(bus.rd_data), 32'(3'b011));
        chk("pop3_vld", 32'(bus.rd_valid), 1);
        chk("drain_count", 32'(bus.count), 0);
        chk("drain_empty", 32'(bus.empty), 1);
        cyc(0, 2'b00, 0, 0);
        chk("idle_vld", 32'(bus.rd_valid), 0);
        chk("idle_hold", 32'(bus.rd_data), 32'(3'b011));

        // Empty with write and read together: no bypass
        cyc(1, 2'b10, 0, 1);
        chk("empty_rw_vld", 32'(bus.rd_valid), 0);
        chk("empty_rw_count", 32'(bus.count), 1);
        cyc(0, 2'b00, 0, 1);
        chk("empty_rw_pop", 32'(bus.rd_data), 32'(3'b010));

        // Overfill
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2'(i + 1), 0, 0);
            if (i == 3) begin
                chk("fill4_full", 32'(bus.full), 1);
                chk("fill4_ovf", 32'(bus.overflow), 0);
            end
        end
        chk("ovf_set", 32'(bus.overflow), 1);
        chk("ovf_count", 32'(bus.count), 4);

        // Full with write and read together: write dropped
        cyc(1, 2'b11, 1, 1);
        chk("full_rw_data", 32'(bus.rd_data), 32'(3'b001));
        chk("full_rw_count", 32'(bus.count), 3);
        chk("full_rw_ovf", 32'(bus.overflow), 1);
        cyc(0, 2'b00, 0, 1);
        chk("full_rw_pop2", 32'(bus.rd_data), 32'(3'b010));
        cyc(0, 2'b00, 0, 1);
        chk("full_rw_pop3", 32'(bus.rd_data), 32'(3'b011));
        cyc(0, 2'b00, 0, 1);
        chk("full_rw_pop4", 32'(bus.rd_data), 32'(3'b000));
        cyc(0, 2'b00, 0, 1);
        chk("full_rw_absent", 32'(bus.rd_valid), 0);

        // Pointer wrap with occupancy held at one
        cyc(1, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 2'(i), ent(i) >> BITS, 1);
            chk("wrap_data", 32'(bus.rd_data), 32'((i == 0) ? ent(0) & 3'b011 : ent(i - 1)));
            chk("wrap_count", 32'(bus.count), 1);
        end
        cyc(0, 2'b00, 0, 1);
        chk("wrap_last", 32'(bus.rd_data), 32'(ent(9)));
        chk("wrap_empty", 32'(bus.empty), 1);

        // Detector: 1,1,(gap),1,0 then 1,0,1,1,0
        cyc(1, 2'd0, 1, 1); chk("detA1", 32'(bus.match), 0);
        cyc(1, 2'd1, 1, 1); chk("detA2", 32'(bus.match), 0);
        cyc(0, 2'd0, 0, 1); chk("detA_gap", 32'(bus.match), 0);
        cyc(1, 2'd2, 1, 1); chk("detA3", 32'(bus.match), 0);
        cyc(1, 2'd3, 0, 1); chk("detA4", 32'(bus.match), 1);
        cyc(1, 2'd0, 1, 1); chk("detB1", 32'(bus.match), 0);
        cyc(1, 2'd1, 0, 1); chk("detB2", 32'(bus.match), 0);
        cyc(1, 2'd2, 1, 1); chk("detB3", 32'(bus.match), 0);
        cyc(1, 2'd3, 1, 1); chk("detB4", 32'(bus.match), 0);
        cyc(1, 2'd0, 0, 1); chk("detB5", 32'(bus.match), 1);
        cyc(0, 2'd0, 0, 1); chk("det_pulse_end", 32'(bus.match), 0);
        for (int i = 0; i < 3; i++) cyc(0, 2'd0, 0, 1);

        // Mid-operation reset with detector armed
        cyc(1, 2'd1, 1, 0);
        cyc(1, 2'd2, 1, 0);
        cyc(1, 2'd3, 1, 0);
        chk("pre_rst_count", 32'(bus.count), 3);
        reset_n = 1'b0;
        cyc(1, 2'd2, 0, 1);
        reset_n = 1'b1;
        chk("mid_rst_count", 32'(bus.count), 0);
        chk("mid_rst_empty", 32'(bus.empty), 1);
        chk("mid_rst_ovf", 32'(bus.overflow), 0);
        chk("mid_rst_match", 32'(bus.match), 0);
        cyc(0, 2'd0, 0, 1);
        chk("post_rst_pop_vld", 32'(bus.rd_valid), 0);
        chk("post_rst_pop_data", 32'(bus.rd_data), 0);
        cyc(1, 2'd1, 1, 0);
        cyc(1, 2'd2, 0, 0);
        chk("post_rst_fsm_idle", 32'(bus.match), 0);
        chk("post_rst_count", 32'(bus.count), 2);
        cyc(0, 2'd0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
